channel_readout_arbiter: RTL and testbench

Shares the host readout path between N_CH capture channels. Round-robin selects a channel whose FIFO reports data available and issues a read strobe to it. It waits out the channel's read latency, captures the 32-bit sample word, and presents it with its channel index on a valid/ready output stream. The block sits between the channel instances and the host serializer (UART/SPI framer).

---
 rtl/la_pkg.sv | 23 ++
 rtl/channel_readout_arbiter_if.sv | 26 ++
 rtl/rr_arbiter.sv | 29 ++
 rtl/channel_readout_arbiter.sv | 125 ++++++++++++
 tb/tb_channel_readout_arbiter.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/la_pkg.sv
// Shared types and helpers for the channel readout arbiter.
package la_pkg;

  localparam int unsigned N_CH_DEF   = 4;
  localparam int unsigned DW_DEF     = 32;
  localparam int unsigned RD_LAT_DEF = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_STROBE  = 3'd1,
    ST_WAIT    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_OUT     = 3'd4
  } state_e;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while (r < 32 && (64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

endpackage

// File: rtl/channel_readout_arbiter_if.sv
// Channel-side read handshake and host-side valid/ready stream of the readout arbiter.
interface channel_readout_arbiter_if
  import la_pkg::*;
#(
  parameter int unsigned N_CH = N_CH_DEF,
  parameter int unsigned CH_W = clog2(N_CH),
  parameter int unsigned DW   = DW_DEF
);
  logic [N_CH-1:0]    ch_available;
  logic [N_CH*DW-1:0] ch_data;
  logic [N_CH-1:0]    ch_read;
  logic               o_valid;
  logic [DW-1:0]      o_data;
  logic [CH_W-1:0]    o_ch;
  logic               i_ready;

  modport master (
    input  ch_available, ch_data, i_ready,
    output ch_read, o_valid, o_data, o_ch
  );

  modport slave (
    output ch_available, ch_data, i_ready,
    input  ch_read, o_valid, o_data, o_ch
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting channel at or above ptr, wrapping at N_CH.
module rr_arbiter #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = 2
) (
  input  logic [N_CH-1:0] req_i,
  input  logic [CH_W-1:0] ptr_i,
  output logic [CH_W-1:0] grant_o,
  output logic            any_req_o
);

  int unsigned idx;

  // ptr_i is always < N_CH, so a single subtract implements the wrap
  always_comb begin
    grant_o   = '0;
    any_req_o = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      idx = 32'(ptr_i) + i;
      if (idx >= N_CH) idx = idx - N_CH;
      if (!any_req_o && req_i[CH_W'(idx)]) begin
        grant_o   = CH_W'(idx);
        any_req_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/channel_readout_arbiter.sv
// Round-robin readout of N_CH channel FIFOs onto one valid/ready word stream tagged with channel index.
module channel_readout_arbiter
  import la_pkg::*;
#(
  parameter int unsigned N_CH   = N_CH_DEF,
  parameter int unsigned CH_W   = clog2(N_CH),
  parameter int unsigned DW     = DW_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic i_clk,
  input  logic _mrst,
  input  logic i_enable,
  output logic o_busy,
  channel_readout_arbiter_if.master bus
);

  localparam int unsigned CNT_W = (RD_LAT > 2) ? clog2(RD_LAT) : 1;

  state_e            state_q, state_d;
  logic [CH_W-1:0]   grant_q, grant_d;
  logic [CH_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_CH-1:0]   ch_read_q, ch_read_d;
  logic              o_valid_q, o_valid_d;
  logic [DW-1:0]     o_data_q, o_data_d;
  logic [CH_W-1:0]   o_ch_q, o_ch_d;
  logic              busy_q, busy_d;
  logic [CH_W-1:0]   rr_grant;
  logic              rr_any;
  logic [DW-1:0]     sel_data;
  logic [CH_W-1:0]   grant_inc;

  rr_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) u_rr (
    .req_i     (bus.ch_available),
    .ptr_i     (ptr_q),
    .grant_o   (rr_grant),
    .any_req_o (rr_any)
  );

  // Word of the granted channel
  always_comb begin
    sel_data = '0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (grant_q == CH_W'(k)) sel_data = bus.ch_data[k*DW +: DW];
    end
  end

  assign grant_inc = (grant_q == CH_W'(N_CH - 1)) ? '0 : grant_q + CH_W'(1);

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    ch_read_d = '0;
    o_valid_d = o_valid_q;
    o_data_d  = o_data_q;
    o_ch_d    = o_ch_q;

    case (state_q)
      ST_IDLE: begin
        if (i_enable && rr_any) begin
          grant_d             = rr_grant;
          ch_read_d[rr_grant] = 1'b1;
          state_d             = ST_STROBE;
        end
      end
      ST_STROBE: begin
        cnt_d   = CNT_W'(RD_LAT - 1);
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_CAPTURE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      ST_CAPTURE: begin
        o_data_d  = sel_data;
        o_ch_d    = grant_q;
        o_valid_d = 1'b1;
        state_d   = ST_OUT;
      end
      ST_OUT: begin
        if (bus.i_ready) begin
          o_valid_d = 1'b0;
          ptr_d     = grant_inc;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_clk or negedge _mrst) begin
    if (!_mrst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      cnt_q     <= '0;
      ch_read_q <= '0;
      o_valid_q <= 1'b0;
      o_data_q  <= '0;
      o_ch_q    <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      ch_read_q <= ch_read_d;
      o_valid_q <= o_valid_d;
      o_data_q  <= o_data_d;
      o_ch_q    <= o_ch_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.ch_read = ch_read_q;
  assign bus.o_valid = o_valid_q;
  assign bus.o_data  = o_data_q;
  assign bus.o_ch    = o_ch_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_channel_readout_arbiter.sv
// Bench for channel_readout_arbiter: 4-channel instance with random traffic, 3-channel instance for index wrap.
module tb_channel_readout_arbiter;
  import la_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned RL = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic en3 = 1'b0;
  logic busy, busy3;

  int checks = 0;
  int errors = 0;
  int ptr_m = 0;
  int ptr3_m = 0;
  int cyc = 0;
  int last_rd = 0;
  bit have_last = 1'b0;

  logic [DW-1:0] chd [N];
  logic [DW-1:0] chd3 [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  channel_readout_arbiter_if #(.N_CH(N), .CH_W(CW), .DW(DW)) bus ();
  channel_readout_arbiter_if #(.N_CH(3), .CH_W(2), .DW(DW)) bus3 ();

  for (genvar g = 0; g < N; g++) begin : g_d4
    assign bus.ch_data[g*DW +: DW] = chd[g];
  end
  for (genvar g = 0; g < 3; g++) begin : g_d3
    assign bus3.ch_data[g*DW +: DW] = chd3[g];
  end

  channel_readout_arbiter #(.N_CH(N), .CH_W(CW), .DW(DW), .RD_LAT(RL)) dut (
    .i_clk(clk), ._mrst(rst_n), .i_enable(en), .o_busy(busy), .bus(bus.master)
  );

  channel_readout_arbiter #(.N_CH(3), .CH_W(2), .DW(DW), .RD_LAT(RL)) dut3 (
    .i_clk(clk), ._mrst(rst_n), .i_enable(en3), .o_busy(busy3), .bus(bus3.master)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference rule: first available channel searching upward from the pointer, modulo n
  function automatic int rr_pick(input logic [N-1:0] mask, input int p, input int n);
    int c;
    for (int i = 0; i < n; i++) begin
      c = (p + i) % n;
      if (mask[c]) return c;
    end
    return -1;
  endfunction

  task automatic do_txn(input logic [N-1:0] mask, input bit ready_early, input int delay, input bit drop_en);
    int exp_ch;
    int k;
    logic [DW-1:0] exp_d;
    exp_ch = rr_pick(mask, ptr_m, N);
    for (int c = 0; c < N; c++) chd[c] = $urandom;
    bus.ch_available = mask;
    bus.i_ready = ready_early;
    k = 0;
    while (bus.ch_read == '0 && k < 20) begin @(negedge clk); k++; end
    chk("strobe_seen", 64'(bus.ch_read != '0), 1);
    if (bus.ch_read == '0) begin
      bus.i_ready = 1'b1; repeat (20) @(negedge clk); bus.i_ready = 1'b0; return;
    end
    chk("ch_read", 64'(bus.ch_read), 64'(N'(1) << exp_ch));
    if (have_last) chk("read_spacing", 64'((cyc - last_rd) >= int'(RL + 4)), 1);
    last_rd = cyc;
    have_last = 1'b1;
    @(negedge clk);
    chk("strobe_one_cycle", 64'(bus.ch_read), 0);
    if (drop_en) en = 1'b0;
    else bus.ch_available = N'($urandom);
    k = 1;
    while (!bus.o_valid && k < 20) begin @(negedge clk); k++; end
    chk("latency", 64'(k), 64'(RL + 2));
    chk("o_ch", 64'(bus.o_ch), 64'(exp_ch));
    chk("o_data", 64'(bus.o_data), 64'(chd[exp_ch]));
    chk("busy_out", 64'(busy), 1);
    exp_d = chd[exp_ch];
    for (int c = 0; c < N; c++) chd[c] = $urandom;
    for (int d = 0; d < delay; d++) begin
      @(negedge clk);
      chk("hold_valid", 64'(bus.o_valid), 1);
      chk("hold_data", 64'(bus.o_data), 64'(exp_d));
      chk("hold_ch", 64'(bus.o_ch), 64'(exp_ch));
      chk("hold_no_read", 64'(bus.ch_read), 0);
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("accept_drop", 64'(bus.o_valid), 0);
    bus.i_ready = 1'b0;
    ptr_m = (exp_ch + 1) % N;
    if (drop_en) begin
      bus.ch_available = mask;
      for (int d = 0; d < 8; d++) begin
        @(negedge clk);
        chk("disabled_busy", 64'(busy), 0);
        chk("disabled_read", 64'(bus.ch_read), 0);
      end
      en = 1'b1;
      have_last = 1'b0;
    end
  endtask

  task automatic txn3(input logic [2:0] mask);
    int exp_ch;
    int k;
    exp_ch = rr_pick(N'(mask), ptr3_m, 3);
    for (int c = 0; c < 3; c++) chd3[c] = $urandom;
    bus3.ch_available = mask;
    bus3.i_ready = 1'b1;
    k = 0;
    while (bus3.ch_read == '0 && k < 20) begin @(negedge clk); k++; end
    chk("w3_read", 64'(bus3.ch_read), 64'(3'(1) << exp_ch));
    k = 0;
    while (!bus3.o_valid && k < 20) begin @(negedge clk); k++; end
    chk("w3_ch", 64'(bus3.o_ch), 64'(exp_ch));
    chk("w3_data", 64'(bus3.o_data), 64'(chd3[exp_ch]));
    bus3.ch_available = '0;
    @(negedge clk);
    chk("w3_accept", 64'(bus3.o_valid), 0);
    bus3.i_ready = 1'b0;
    ptr3_m = (exp_ch + 1) % 3;
  endtask

  initial begin
    int k;
    logic [N-1:0] m;
    bit early;
    int dl;
    bus.ch_available = '0;
    bus.i_ready = 1'b0;
    bus3.ch_available = '0;
    bus3.i_ready = 1'b0;
    for (int c = 0; c < N; c++) chd[c] = '0;
    for (int c = 0; c < 3; c++) chd3[c] = '0;

    repeat (3) @(negedge clk);
    chk("rst_valid", 64'(bus.o_valid), 0);
    chk("rst_read", 64'(bus.ch_read), 0);
    chk("rst_ch", 64'(bus.o_ch), 0);
    chk("rst_data", 64'(bus.o_data), 0);
    chk("rst_busy", 64'(busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    en = 1'b1;
    en3 = 1'b1;

    // Single channel with a known word
    do_txn(4'b0100, 1'b1, 0, 1'b0);
    chd[2] = 32'hDEADBEEF;
    bus.ch_available = 4'b0100;
    bus.i_ready = 1'b1;
    k = 0;
    while (bus.ch_read == '0 && k < 20) begin @(negedge clk); k++; end
    chk("single_read", 64'(bus.ch_read), 64'(4'b0100));
    repeat (5) @(negedge clk);
    chk("single_valid", 64'(bus.o_valid), 1);
    chk("single_data", 64'(bus.o_data), 64'(32'hDEADBEEF));
    chk("single_ch", 64'(bus.o_ch), 2);
    @(negedge clk);
    bus.i_ready = 1'b0;
    ptr_m = 3;
    have_last = 1'b0;

    // Move pointer to 1, then reset mid-OUT
    do_txn(4'b0001, 1'b0, 0, 1'b0);
    bus.ch_available = 4'hF;
    bus.i_ready = 1'b0;
    k = 0;
    while (!bus.o_valid && k < 20) begin @(negedge clk); k++; end
    chk("pre_rst_valid", 64'(bus.o_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.o_valid), 0);
    chk("arst_read", 64'(bus.ch_read), 0);
    chk("arst_ch", 64'(bus.o_ch), 0);
    chk("arst_busy", 64'(busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    ptr_m = 0;
    have_last = 1'b0;

    // Round-robin over all channels with ready held high
    for (int i = 0; i < 5; i++) do_txn(4'hF, 1'b1, 0, 1'b0);

    do_txn(4'b0010, 1'b0, 20, 1'b0);
    do_txn(4'b1000, 1'b0, 0, 1'b1);

    for (int i = 0; i < 30; i++) begin
      m = N'($urandom_range(1, (1 << N) - 1));
      early = 1'($urandom_range(0, 1));
      dl = early ? 0 : $urandom_range(0, 3);
      do_txn(m, early, dl, 1'($urandom_range(0, 7) == 0));
    end

    txn3(3'b010);
    txn3(3'b001);
    chk("w3_ptr_model", 64'(ptr3_m), 1);
    txn3(3'b101);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
